// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the device emulator and the host controller:
// link state encodings, frame geometry and the parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INHIBIT,
    TX,
    RX
  } ps2_state_e;

  localparam int FRAME_BITS  = 11;
  localparam int SYNC_MARGIN = 2;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_device_emulator_clk_tick.sv
// Half-period timer for the generated PS2_CLK: free-runs, wraps on tick and is
// forced back to zero by restart.
module ps2_clk_tick #(
  parameter int HALF = 2500,
  parameter int CW   = $clog2(HALF)
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          restart,
  output logic          tick,
  output logic [CW-1:0] count
);

  assign tick = (count == CW'(HALF - 1));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)               count <= '0;
    else if (restart || tick) count <= '0;
    else                     count <= count + 1'b1;
  end

endmodule

// File: rtl/ps2_device_emulator.sv
// PS/2 device end: sends held bytes as device-to-host frames, answers host
// request-to-send by clocking in a command and acking it. Lines are open-drain.
module ps2_device_emulator
  import ps2_pkg::*;
#(
  parameter int CLK_HALF_PERIOD = 2500,
  parameter int INHIBIT_CYCLES  = 5000,
  parameter int GAP_CYCLES      = 5000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_aborted,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       busy,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);

  localparam int         HALF_W   = $clog2(CLK_HALF_PERIOD);
  localparam int         INH_W    = $clog2(INHIBIT_CYCLES + 1);
  localparam int         GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  ps2_state_e        state, state_n;
  logic [3:0]        bit_cnt, bit_n;
  logic              phase_low, phase_low_n;
  logic              clk_drv, clk_drv_n, dat_drv, dat_drv_n;
  logic              clk_meta, clk_sync, dat_meta, dat_sync;
  logic              held;
  logic [1:0]        held_q;
  logic [7:0]        hold_data;
  logic [9:0]        rx_shift;
  logic [INH_W-1:0]  inh_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [HALF_W-1:0] half_cnt;
  logic              tick, restart, inh_done, gap_done;
  logic              tx_done, abort, rx_sample, rx_done;
  logic [FRAME_BITS-1:0] tx_frame;

  assign PS2_CLK  = clk_drv ? 1'b0 : 1'bz;
  assign PS2_DAT  = dat_drv ? 1'b0 : 1'bz;
  assign tx_ready = ~held;
  assign busy     = (state != IDLE);
  assign tx_frame = {1'b1, odd_parity(hold_data), hold_data, 1'b0};
  assign restart  = (state_n != state);
  assign inh_done = (inh_cnt == INH_W'(INHIBIT_CYCLES));
  assign gap_done = (gap_cnt == GAP_W'(GAP_CYCLES));

  ps2_clk_tick #(.HALF(CLK_HALF_PERIOD), .CW(HALF_W)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .restart  (restart),
    .tick     (tick),
    .count    (half_cnt)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    // NOTE: sequential logic uses <= so every register samples pre-edge values.
    if (reset) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= PS2_CLK;
      clk_sync <= clk_meta;
      dat_meta <= PS2_DAT;
      dat_sync <= dat_meta;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      phase_low <= 1'b0;
      clk_drv   <= 1'b0;
      dat_drv   <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_n;
      phase_low <= phase_low_n;
      clk_drv   <= clk_drv_n;
      dat_drv   <= dat_drv_n;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first; a missed branch would otherwise infer a latch.
    state_n     = state;
    bit_n       = bit_cnt;
    phase_low_n = phase_low;
    clk_drv_n   = clk_drv;
    dat_drv_n   = dat_drv;
    tx_done     = 1'b0;
    abort       = 1'b0;
    rx_sample   = 1'b0;
    rx_done     = 1'b0;
    unique case (state)
      IDLE: begin
        clk_drv_n = 1'b0;
        dat_drv_n = 1'b0;
        if (!clk_sync) begin
          state_n = INHIBIT;
        end else if (held && held_q[1] && gap_done) begin
          state_n     = TX;
          bit_n       = '0;
          phase_low_n = 1'b0;
          dat_drv_n   = ~tx_frame[0];
        end
      end
      INHIBIT: begin
        if (clk_sync) begin
          if (!dat_sync && inh_done) begin
            state_n     = RX;
            bit_n       = '0;
            phase_low_n = 1'b1;
            clk_drv_n   = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      TX: begin
        if (!phase_low) begin
          // Our own low half takes SYNC_MARGIN cycles to leave clk_sync.
          if (!clk_sync && half_cnt >= HALF_W'(SYNC_MARGIN) && bit_cnt != LAST_BIT) begin
            abort     = 1'b1;
            state_n   = INHIBIT;
            clk_drv_n = 1'b0;
            dat_drv_n = 1'b0;
          end else if (tick) begin
            phase_low_n = 1'b1;
            clk_drv_n   = 1'b1;
          end
        end else if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            tx_done   = 1'b1;
            state_n   = IDLE;
            clk_drv_n = 1'b0;
            dat_drv_n = 1'b0;
          end else begin
            bit_n       = bit_cnt + 4'd1;
            phase_low_n = 1'b0;
            clk_drv_n   = 1'b0;
            dat_drv_n   = ~tx_frame[bit_cnt + 4'd1];
          end
        end
      end
      RX: begin
        if (tick) begin
          if (phase_low) begin
            phase_low_n = 1'b0;
            clk_drv_n   = 1'b0;
            rx_sample   = (bit_cnt != LAST_BIT);
          end else if (bit_cnt == LAST_BIT) begin
            rx_done   = 1'b1;
            state_n   = IDLE;
            clk_drv_n = 1'b0;
            dat_drv_n = 1'b0;
          end else begin
            bit_n       = bit_cnt + 4'd1;
            phase_low_n = 1'b1;
            clk_drv_n   = 1'b1;
            dat_drv_n   = (bit_cnt + 4'd1 == LAST_BIT);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // held_q delays TX start so a host request coinciding with the accept wins.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      held   <= 1'b0;
      held_q <= '0;
    end else begin
      if (tx_done)                held <= 1'b0;
      else if (tx_valid && !held) held <= 1'b1;
      held_q <= {held_q[0], held};
    end
  end

  // NOTE: hold_data and rx_shift carry no reset; they are only read once filled.
  always_ff @(posedge CLOCK_50) begin
    if (tx_valid && !held) hold_data <= tx_data;
    if (rx_sample)         rx_shift  <= {dat_sync, rx_shift[9:1]};
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      inh_cnt       <= '0;
      gap_cnt       <= '0;
      tx_aborted    <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      if (state != INHIBIT)         inh_cnt <= '0;
      else if (!clk_sync && !inh_done) inh_cnt <= inh_cnt + 1'b1;
      if (state != IDLE)            gap_cnt <= '0;
      else if (!gap_done)           gap_cnt <= gap_cnt + 1'b1;
      tx_aborted <= abort;
      rx_valid   <= rx_done;
      if (rx_done) begin
        rx_data       <= rx_shift[7:0];
        rx_parity_err <= (rx_shift[8] != odd_parity(rx_shift[7:0]));
        rx_frame_err  <= ~rx_shift[9];
      end
    end
  end

endmodule

// File: tb/tb_ps2_device_emulator.sv
// Bench for ps2_device_emulator: a host BFM drives request-to-send and commands,
// a line monitor decodes device frames, and queues hold the expected results.
module tb_ps2_device_emulator;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] tx_data  = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_aborted, rx_valid, rx_parity_err, rx_frame_err, busy;
  logic [7:0] rx_data;
  wire        ps2_clk, ps2_dat;

  logic h_clk_low   = 1'b0;
  logic h_dat_low   = 1'b0;
  bit   host_active = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = h_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = h_dat_low ? 1'b0 : 1'bz;

  ps2_device_emulator #(
    .CLK_HALF_PERIOD (10),
    .INHIBIT_CYCLES  (40),
    .GAP_CYCLES      (40)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_aborted    (tx_aborted),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .busy          (busy),
    .PS2_CLK       (ps2_clk),
    .PS2_DAT       (ps2_dat)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_exp[$];
  logic [9:0]  rx_exp[$];
  int          mon_bits = 0;
  logic [10:0] mon_frame = '0;
  logic [10:0] last_frame = '0;
  logic        mon_prev_clk = 1'b1;
  int          frames_done = 0;
  int          abort_cnt = 0;
  int          rx_pulses = 0;
  logic [7:0]  exp_b;
  logic [9:0]  exp_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line monitor: device frames are read on PS2_CLK falling edges.
  always @(negedge CLOCK_50) begin
    if (host_active || reset) begin
      mon_bits = 0;
    end else if (mon_prev_clk && !ps2_clk) begin
      mon_frame[mon_bits] = ps2_dat;
      mon_bits++;
      if (mon_bits == 11) begin
        last_frame = mon_frame;
        frames_done++;
        mon_bits = 0;
        if (tx_exp.size() == 0) begin
          check("tx_spurious_frame", 32'(mon_frame), 32'h0);
        end else begin
          exp_b = tx_exp.pop_front();
          check("tx_frame", 32'(mon_frame), 32'({1'b1, ~^exp_b, exp_b, 1'b0}));
        end
      end
    end
    mon_prev_clk = ps2_clk;
    if (tx_aborted) abort_cnt++;
    if (rx_valid) begin
      rx_pulses++;
      if (rx_exp.size() == 0) begin
        check("rx_spurious", 32'(rx_valid), 32'h0);
      end else begin
        exp_r = rx_exp.pop_front();
        check("rx_result", 32'({rx_data, rx_parity_err, rx_frame_err}), 32'(exp_r));
      end
    end
  end

  task automatic wait_clk_fall(output bit seen);
    logic prev;
    prev = ps2_clk;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge CLOCK_50);
      if (prev && !ps2_clk) seen = 1'b1;
      prev = ps2_clk;
    end
  endtask

  // Host request-to-send, then serve n_clocks device clocks (11 = full command).
  task automatic host_send(input logic [7:0] d, input logic par_flip,
                           input logic stop_val, input int n_clocks);
    logic [10:0] bits;
    bit          seen;
    int          n;
    bits = {stop_val, (~^d) ^ par_flip, d, 1'b0};
    if (n_clocks == 11) rx_exp.push_back({d, par_flip, ~stop_val});
    host_active = 1'b1;
    @(posedge CLOCK_50); #1;
    h_clk_low = 1'b1;
    repeat (60) @(posedge CLOCK_50);
    #1 h_dat_low = 1'b1;
    repeat (5) @(posedge CLOCK_50);
    #1 h_clk_low = 1'b0;
    for (int k = 1; k <= n_clocks; k++) begin
      wait_clk_fall(seen);
      if (!seen) begin
        check("host_clk_fall", 32'(seen), 32'h1);
        h_dat_low   = 1'b0;
        host_active = 1'b0;
        return;
      end
      if (k <= 10) begin
        h_dat_low = ~bits[k];
      end else begin
        h_dat_low = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("ack_low", 32'(ps2_dat), 32'h0);
        n = 0;
        while (!ps2_dat && n < 100) begin
          @(negedge CLOCK_50);
          n++;
        end
        check("ack_release", 32'(ps2_dat), 32'h1);
      end
    end
    if (n_clocks == 11) host_active = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(posedge CLOCK_50); #1;
    check("tx_ready_before_send", 32'(tx_ready), 32'h1);
    tx_data  = d;
    tx_valid = 1'b1;
    tx_exp.push_back(d);
    @(posedge CLOCK_50); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((tx_exp.size() != 0 || rx_exp.size() != 0 || !tx_ready || busy) && n < 3000) begin
      @(negedge CLOCK_50);
      n++;
    end
    check(tag, 32'(n < 3000), 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, ab0, rp0;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("rst_tx_ready", 32'(tx_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_tx_aborted", 32'(tx_aborted), 32'h0);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_errs", 32'({rx_parity_err, rx_frame_err}), 32'h0);
    check("rst_lines", 32'({ps2_clk, ps2_dat}), 32'h3);

    // 1: plain transmit
    f0 = frames_done;
    send_byte(8'h1C);
    wait_idle("t1_done");
    check("t1_frame_bits", 32'(last_frame), 32'h438);
    check("t1_frame_count", 32'(frames_done - f0), 32'h1);

    // 2: host command
    host_send(8'hF4, 1'b0, 1'b1, 11);
    wait_idle("t2_done");

    // 3: bad parity, then bad stop bit
    host_send(8'hF4, 1'b1, 1'b1, 11);
    wait_idle("t3_parity_done");
    host_send(8'h3A, 1'b0, 1'b0, 11);
    wait_idle("t3_stop_done");

    // 4: host inhibit during data bit D4 of 8'hAA
    f0  = frames_done;
    ab0 = abort_cnt;
    send_byte(8'hAA);
    begin
      int n;
      n = 0;
      while (!(mon_bits == 5 && ps2_clk) && n < 2000) begin
        @(negedge CLOCK_50);
        n++;
      end
      check("t4_reach_bit", 32'(mon_bits), 32'h5);
    end
    repeat (4) @(negedge CLOCK_50);
    host_active = 1'b1;
    h_clk_low   = 1'b1;
    repeat (60) @(negedge CLOCK_50);
    check("t4_abort_pulse", 32'(abort_cnt - ab0), 32'h1);
    check("t4_dat_released", 32'(ps2_dat), 32'h1);
    check("t4_still_held", 32'(tx_ready), 32'h0);
    h_clk_low   = 1'b0;
    host_active = 1'b0;
    wait_idle("t4_resend_done");
    check("t4_frame_count", 32'(frames_done - f0), 32'h1);
    check("t4_abort_total", 32'(abort_cnt - ab0), 32'h1);

    // 5: host request and tx_valid in the same cycle
    f0  = frames_done;
    ab0 = abort_cnt;
    rp0 = rx_pulses;
    fork
      host_send(8'hED, 1'b0, 1'b1, 11);
      send_byte(8'h55);
    join
    @(negedge CLOCK_50);
    check("t5_rx_first", 32'(rx_pulses - rp0), 32'h1);
    check("t5_tx_not_yet", 32'(frames_done - f0), 32'h0);
    wait_idle("t5_done");
    check("t5_tx_sent", 32'(frames_done - f0), 32'h1);
    check("t5_no_abort", 32'(abort_cnt - ab0), 32'h0);

    // 6: reset during receive clock 5
    rp0 = rx_pulses;
    host_send(8'hFF, 1'b0, 1'b1, 5);
    @(negedge CLOCK_50);
    #2 reset = 1'b1;
    #1;
    check("t6_clk_released", 32'(ps2_clk), 32'h1);
    check("t6_busy", 32'(busy), 32'h0);
    h_dat_low = 1'b0;
    #1;
    check("t6_dat_released", 32'(ps2_dat), 32'h1);
    repeat (3) @(negedge CLOCK_50);
    reset       = 1'b0;
    host_active = 1'b0;
    repeat (100) @(negedge CLOCK_50);
    check("t6_no_rx_valid", 32'(rx_pulses - rp0), 32'h0);
    f0 = frames_done;
    send_byte(8'h1C);
    wait_idle("t6_tx_done");
    check("t6_frame_bits", 32'(last_frame), 32'h438);
    check("t6_frame_count", 32'(frames_done - f0), 32'h1);

    check("queues_empty", 32'(tx_exp.size() + rx_exp.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
